// File: rtl/output_backprop_pkg.sv
// Shared widths, FSM encoding and snapshot payload for the output-neuron backward pass.
package output_backprop_pkg;

  localparam int unsigned N_IN    = 8;
  localparam int unsigned X_W     = 10;
  localparam int unsigned W_W     = 8;
  localparam int unsigned F_W     = 23;
  localparam int unsigned T_W     = 4;
  localparam int unsigned ERR_W   = 24;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned X_BUS_W = N_IN * X_W;
  localparam int unsigned W_BUS_W = N_IN * W_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR  = 2'd1,
    UPD  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Inputs captured at the start edge; only these are used afterwards
  typedef struct packed {
    logic [F_W-1:0]     final_v;
    logic [T_W-1:0]     target_v;
    logic [X_BUS_W-1:0] x;
  } snap_t;

endpackage

// File: rtl/output_backprop_weight_update_lane.sv
// One weight update: w - floor((err * x) / 2^LR_SHIFT), clamped to [0, W_MAX].
module output_backprop_weight_update_lane
  import output_backprop_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 10,
  parameter int unsigned W_MAX    = 255
) (
  input  logic signed [ERR_W-1:0] err_i,
  input  logic        [X_W-1:0]   x_i,
  input  logic        [W_W-1:0]   w_i,
  output logic        [W_W-1:0]   w_new_o
);

  localparam int unsigned G_W = ERR_W + X_W + 1;
  localparam int unsigned C_W = G_W + 1;

  logic signed [G_W-1:0] err_ext;
  logic signed [G_W-1:0] x_ext;
  logic signed [G_W-1:0] grad;
  logic signed [G_W-1:0] delta;
  logic signed [C_W-1:0] cand;

  // Signed gradient, arithmetic shift (floor) and saturating subtract
  always_comb begin
    err_ext = {{(G_W-ERR_W){err_i[ERR_W-1]}}, err_i};
    x_ext   = {{(G_W-X_W){1'b0}}, x_i};
    grad    = err_ext * x_ext;
    delta   = grad >>> LR_SHIFT;
    cand    = {{(C_W-W_W){1'b0}}, w_i} - {delta[G_W-1], delta};
    if (cand[C_W-1]) begin
      w_new_o = '0;
    end else if (cand > C_W'(W_MAX)) begin
      w_new_o = W_W'(W_MAX);
    end else begin
      w_new_o = cand[W_W-1:0];
    end
  end

endmodule

// File: rtl/output_backprop.sv
// Backward pass of the output neuron: error, then one weight update per cycle.
module output_backprop
  import output_backprop_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 10,
  parameter int unsigned W_MAX    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic        [F_W-1:0]   final_i,
  input  logic        [T_W-1:0]   target_i,
  input  logic        [X_BUS_W-1:0] x_i,
  input  logic        [W_BUS_W-1:0] weights_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic signed [ERR_W-1:0] err_o,
  output logic        [W_BUS_W-1:0] weights_o
);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  snap_t            snap_q;
  logic             busy_d;
  logic             done_d;
  logic [X_W-1:0]   lane_x;
  logic [W_W-1:0]   lane_w;
  logic [W_W-1:0]   lane_w_new;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ERR;
      ERR:     state_d = UPD;
      UPD:     if (idx_q == IDX_W'(N_IN - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flag decode from the upcoming state so the flags register in step with it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == ERR || state_d == UPD) busy_d = 1'b1;
    if (state_d == DONE)                  done_d = 1'b1;
  end

  // Shared lane operands selected by the update index
  always_comb begin
    lane_x = snap_q.x[idx_q*X_W +: X_W];
    lane_w = weights_o[idx_q*W_W +: W_W];
  end

  output_backprop_weight_update_lane #(
    .LR_SHIFT (LR_SHIFT),
    .W_MAX    (W_MAX)
  ) u_lane (
    .err_i   (err_o),
    .x_i     (lane_x),
    .w_i     (lane_w),
    .w_new_o (lane_w_new)
  );

  // Snapshot, error, per-lane writeback and registered flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      snap_q    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= '0;
      weights_o <= '0;
    end else begin
      busy_o <= busy_d;
      done_o <= done_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            snap_q.final_v  <= final_i;
            snap_q.target_v <= target_i;
            snap_q.x        <= x_i;
            weights_o       <= weights_i;
          end
        end
        ERR: begin
          err_o <= ERR_W'({1'b0, snap_q.final_v}) - ERR_W'(snap_q.target_v);
          idx_q <= '0;
        end
        UPD: begin
          weights_o[idx_q*W_W +: W_W] <= lane_w_new;
          idx_q                       <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_backprop.sv
// Scoreboard bench for output_backprop: expected error/weights queued at start, checked on done.
module tb_output_backprop;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [22:0] final_i;
  logic [3:0]  target_i;
  logic [79:0] x_i;
  logic [63:0] weights_i;
  logic        busy_o;
  logic        done_o;
  logic [23:0] err_o;
  logic [63:0] weights_o;

  typedef struct {
    logic [23:0] err;
    logic [63:0] w;
    int          exp_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  output_backprop dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .final_i   (final_i),
    .target_i  (target_i),
    .x_i       (x_i),
    .weights_i (weights_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .weights_o (weights_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: integer arithmetic with explicit floor division
  function automatic logic [63:0] model_w(input longint e, input logic [79:0] x, input logic [63:0] w);
    logic [63:0] r;
    longint g, d, c, xv, wv;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      xv = longint'(x[10*k +: 10]);
      wv = longint'(w[8*k +: 8]);
      g  = e * xv;
      if (g >= 0) d = g / 1024;
      else        d = -((-g + 1023) / 1024);
      c = wv - d;
      if (c < 0)        c = 0;
      else if (c > 255) c = 255;
      r[8*k +: 8] = 8'(c);
    end
    return r;
  endfunction

  // Drive one request at a negedge; returns at the negedge of cycle 1
  task automatic start_op(input logic [22:0] f, input logic [3:0] t,
                          input logic [79:0] x, input logic [63:0] w);
    exp_t   ent;
    longint e;
    @(negedge clk_i);
    final_i   = f;
    target_i  = t;
    x_i       = x;
    weights_i = w;
    start_i   = 1'b1;
    e           = longint'(f) - longint'(t);
    ent.err     = 24'(e);
    ent.w       = model_w(e, x, w);
    ent.exp_cyc = cyc + 10;
    exp_q.push_back(ent);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Output monitor: pop and compare whenever done_o is seen
  always @(posedge clk_i) begin
    exp_t ent;
    cyc++;
    #1;
    if (done_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        ent = exp_q.pop_front();
        chk("err_o", 64'(err_o), 64'(ent.err));
        chk("weights_o", weights_o, ent.w);
        chk("done_latency", 64'(cyc), 64'(ent.exp_cyc));
      end
    end
  end

  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b0;
    final_i   = '0;
    target_i  = '0;
    x_i       = '0;
    weights_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_weights", weights_o, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Basic update with busy window check
    start_op(23'd10, 4'd4, {8{10'd512}}, {8{8'd128}});
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("busy_c%0d", i), 64'(busy_o), (i <= 9) ? 64'd1 : 64'd0);
      @(negedge clk_i);
    end
    wait_drain();
    chk("basic_value", weights_o, 64'h7D7D_7D7D_7D7D_7D7D);
    chk("hold_busy", 64'(busy_o), 64'd0);

    // Negative error, floor on shift
    start_op(23'd0, 4'd8, {8{10'd1023}}, {8{8'd128}});
    wait_drain();
    chk("neg_value", weights_o, 64'h8888_8888_8888_8888);
    chk("neg_err", 64'(err_o), 64'h00_FFFFF8);

    // Saturation low then high
    start_op(23'd1000, 4'd0, {8{10'd1023}}, {8{8'd200}});
    wait_drain();
    chk("sat_low", weights_o, 64'd0);
    start_op(23'd0, 4'd15, {8{10'd1023}}, {8{8'd250}});
    wait_drain();
    chk("sat_high", weights_o, 64'hFFFF_FFFF_FFFF_FFFF);

    // Zero error keeps weights
    start_op(23'd4, 4'd4, {10'd7, 10'd100, 10'd1023, 10'd0, 10'd512, 10'd3, 10'd9, 10'd800},
             64'h0102_0304_0506_0708);
    wait_drain();
    chk("zero_err_value", weights_o, 64'h0102_0304_0506_0708);

    // Starts while busy are ignored; start right after done is accepted
    start_op(23'd300, 4'd2, {10'd1, 10'd50, 10'd200, 10'd400, 10'd600, 10'd800, 10'd1000, 10'd1023},
             64'h10_20_30_40_50_60_70_80);
    final_i   = 23'd5;
    target_i  = 4'd9;
    x_i       = {8{10'd999}};
    weights_i = 64'hFFFF_0000_FFFF_0000;
    repeat (2) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("done_cycle10", 64'(done_o), 64'd1);
    start_op(23'd50, 4'd1, {8{10'd300}}, {8{8'd60}});
    wait_drain();
    chk("after_done_busy", 64'(busy_o), 64'd0);

    // Asynchronous reset mid-update, then a clean run
    start_op(23'd2000, 4'd3, {8{10'd700}}, {8{8'd100}});
    repeat (5) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    chk("arst_weights", weights_o, 64'd0);
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    start_op(23'd20, 4'd10, {10'd1023, 10'd0, 10'd512, 10'd256, 10'd128, 10'd64, 10'd32, 10'd16},
             64'hC8_00_FF_01_7F_80_02_FE);
    wait_drain();
    repeat (3) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
